seq_magnitude_compare: RTL and testbench
========================================

Name: seq_magnitude_compare

Overview:
Parametrised, multi-cycle magnitude comparator for the ALU compare path. It generalises the 2-bit greater-than cell to WIDTH bits and adds a signed/unsigned mode. Operands are latched on a start handshake and scanned MSB-first, DIGIT bits per cycle. The scan exits early at the first differing digit. It reports gt/eq/lt with a one-cycle done pulse and the number of digits examined.

Parameters:
WIDTH, 32, operand width in bits; must be an integer multiple of DIGIT.
DIGIT, 2, bits compared per clock cycle; 1 <= DIGIT <= WIDTH.
EARLY_EXIT, 1, 1 = finish at the first differing digit; 0 = always scan all WIDTH/DIGIT digits.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
signed_mode  input  1  1 = two's-complement compare; 0 = unsigned. Latched with the operands.
a  input  WIDTH  operand A; latched on an accepted start.
b  input  WIDTH  operand B; latched on an accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the result becomes valid.
gt  output  1  A > B; held until the next accepted start.
eq  output  1  A == B; held until the next accepted start.
lt  output  1  A < B; held until the next accepted start.
digits_used  output  $clog2(WIDTH/DIGIT)+1  digits examined for the current result; held until the next accepted start.

Behaviour:
- Reset: asynchronous and active-high; reset is already decided as such. While rst=1: state=IDLE; busy, done, gt, eq, lt and digits_used are all 0; the internal operand registers and digit index are 0.
- Reset asserted mid-RUN: the operation is aborted with no done pulse. After rst deasserts, the block restarts from IDLE.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge (E0):
  - Latch a, b and signed_mode.
  - Clear gt/eq/lt and digits_used; set index to 0.
  - Go to RUN; busy=1 from the next cycle.
- Signed mode: the MSB of each latched operand is inverted before comparison. This maps two's-complement order onto unsigned order.
- RUN, each edge:
  - Compare digit[index], MSB-first: bits [WIDTH-1-index*DIGIT -: DIGIT].
  - digits_used <= index+1.
  - Digits differ and EARLY_EXIT=1: set gt or lt from that digit; go to DONE.
  - Digits differ and EARLY_EXIT=0: record the first difference only and continue scanning.
  - Last digit done (index = WIDTH/DIGIT-1): go to DONE. Result is the recorded difference, or eq=1 if none was recorded.
- Entering DONE: done=1 for exactly the one cycle after the transition edge; busy=0 in that same cycle.
  - gt/eq/lt are exactly one-hot while in DONE.
  - Results and digits_used hold until the next accepted start.
- Latency (edges after E0): k, where k is the index of the first differing digit plus one. Maximum is WIDTH/DIGIT; with EARLY_EXIT=0 it is always WIDTH/DIGIT.
- start=1 during RUN: ignored. Operands are not re-latched and the result is not disturbed.
- start=1 in the same cycle that done=1: accepted. The next operation begins and done is not extended.
- Back-to-back starts: no idle cycle is required between a DONE and the next RUN.
- Changes on a, b or signed_mode outside the latch edge have no effect.

Test Plan:
- WIDTH=32, DIGIT=2, unsigned, a=32'hFFFFFFFF, b=32'hFFFFFFFF -> done 16 cycles after E0; eq=1, gt=lt=0, digits_used=16.
- a=32'h80000000, b=32'h7FFFFFFF:
  - unsigned -> done 1 cycle after E0; gt=1, digits_used=1.
  - signed -> lt=1, digits_used=1.
- a=32'd3, b=32'd2, unsigned:
  - EARLY_EXIT=1 -> gt=1 after 16 cycles, digits_used=16.
  - a=32'h00030000, b=32'h00020000 -> gt=1 after 8 cycles.
- Start a=5, b=9. Pulse start with a=9, b=5 at cycle 2 of RUN -> second start ignored; lt=1. Then assert start in the done cycle -> new compare accepted with no gap.
- Assert rst at RUN cycle 5 of an equal-operand compare -> all outputs 0 immediately; no done pulse. A following start a=1, b=0 completes normally with gt=1.
- WIDTH=2, DIGIT=1, unsigned, exhaustive 16 pairs from a=2'b11/b=2'b11 to a=2'b00/b=2'b00 -> gt=1 exactly for 11>10, 11>01, 11>00, 10>01, 10>00 and 01>00; eq=1 on the diagonal; lt=1 otherwise.

Source files
------------

// File: rtl/seq_magnitude_compare.sv
// -----------------------------------------------------------------------------
// seq_magnitude_compare
//
// Multi-cycle magnitude comparator for the ALU compare path. Operands are
// latched on an accepted start and scanned MSB-first, DIGIT bits per clock.
// With EARLY_EXIT=1 the scan stops at the first differing digit. Otherwise
// every digit is visited and the first difference seen decides the result.
// In signed mode the operand MSBs are inverted as they are latched. This maps
// two's-complement order onto plain unsigned order, so the scan itself never
// needs to know the mode.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request; sampled only in IDLE or DONE
//   signed_mode  1 = two's-complement compare, 0 = unsigned (latched)
//   a, b         WIDTH-bit operands (latched on an accepted start)
//   busy         high while the scan is running
//   done         one-cycle pulse when gt/eq/lt become valid
//   gt, eq, lt   result flags, one-hot after done, held until the next start
//   digits_used  number of digits examined for the current result
// -----------------------------------------------------------------------------
module seq_magnitude_compare #(
   parameter int WIDTH      = 32,
   parameter int DIGIT      = 2,
   parameter int EARLY_EXIT = 1,
   localparam int DU_W      = $clog2(WIDTH / DIGIT) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [DU_W-1:0]  digits_used
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDX_W-1:0] r_idx;
   logic             r_found;     // a difference has already been recorded
   logic             r_found_gt;  // direction of that first difference
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;
   logic [DU_W-1:0]  r_du;
   logic             r_done;

   logic [WIDTH-1:0] w_sh_a;
   logic [WIDTH-1:0] w_sh_b;
   logic [DIGIT-1:0] w_dig_a;
   logic [DIGIT-1:0] w_dig_b;
   logic             w_differ;
   logic             w_dig_gt;
   logic             w_last;
   logic             w_finish;
   logic             w_res_diff;
   logic             w_res_gt;

   // Shifting the current digit up to the MSB keeps the select constant,
   // avoiding a variable-base part-select on the operand registers.
   assign w_sh_a  = r_a << (int'(r_idx) * DIGIT);
   assign w_sh_b  = r_b << (int'(r_idx) * DIGIT);
   assign w_dig_a = w_sh_a[WIDTH-1 -: DIGIT];
   assign w_dig_b = w_sh_b[WIDTH-1 -: DIGIT];

   assign w_differ = (w_dig_a != w_dig_b);
   assign w_dig_gt = (w_dig_a > w_dig_b);
   assign w_last   = (r_idx == IDX_W'(NDIG - 1));
   assign w_finish = (w_differ && (EARLY_EXIT != 0)) || w_last;

   // An earlier recorded difference outranks the digit under test, because
   // it is more significant.
   assign w_res_diff = r_found | w_differ;
   assign w_res_gt   = r_found ? r_found_gt : w_dig_gt;

   // NOTE: every register here uses non-blocking assignment so that all of
   // them update together on the edge, with no ordering hazards between reads and writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the operand registers are reset as well. They are plain
         // flops rather than a memory, and starting them from a known value
         // keeps the idle datapath deterministic.
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_idx      <= '0;
         r_found    <= 1'b0;
         r_found_gt <= 1'b0;
         r_gt       <= 1'b0;
         r_eq       <= 1'b0;
         r_lt       <= 1'b0;
         r_du       <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_a        <= signed_mode ? (a ^ MSB_MASK) : a;
                  r_b        <= signed_mode ? (b ^ MSB_MASK) : b;
                  r_idx      <= '0;
                  r_found    <= 1'b0;
                  r_found_gt <= 1'b0;
                  r_gt       <= 1'b0;
                  r_eq       <= 1'b0;
                  r_lt       <= 1'b0;
                  r_du       <= '0;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               r_du <= DU_W'(r_idx) + DU_W'(1);
               if (w_differ && !r_found) begin
                  r_found    <= 1'b1;
                  r_found_gt <= w_dig_gt;
               end
               if (w_finish) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_gt    <= w_res_diff && w_res_gt;
                  r_lt    <= w_res_diff && !w_res_gt;
                  r_eq    <= !w_res_diff;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (r_state == S_RUN);
   assign done        = r_done;
   assign gt          = r_gt;
   assign eq          = r_eq;
   assign lt          = r_lt;
   assign digits_used = r_du;

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// -----------------------------------------------------------------------------
// Bench for seq_magnitude_compare. It drives three instances:
//   u_main  : WIDTH=32, DIGIT=2, EARLY_EXIT=1
//   u_full  : WIDTH=32, DIGIT=2, EARLY_EXIT=0 (own start, shares a/b/mode)
//   u_small : WIDTH=2,  DIGIT=1, EARLY_EXIT=1
// The driver pushes the expected result of every accepted start into a
// per-instance queue. Per-instance monitors pop an entry on each done pulse
// and compare against it. The reference model works on integer values. It
// finds the deciding digit from the highest set bit of a^b.
// -----------------------------------------------------------------------------
module tb_seq_magnitude_compare;

   typedef struct {
      bit gt;
      bit eq;
      bit lt;
      int du;
      int lat;
      int e0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_m, start_f, start_s;
   logic        sg;
   logic [31:0] a, b;
   logic [1:0]  a_s, b_s;

   logic        busy_m, done_m, gt_m, eq_m, lt_m;
   logic        busy_f, done_f, gt_f, eq_f, lt_f;
   logic        busy_s, done_s, gt_s, eq_s, lt_s;
   logic [4:0]  du_m, du_f;
   logic [1:0]  du_s;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q_main[$];
   exp_t q_full[$];
   exp_t q_small[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_magnitude_compare #(.WIDTH(32), .DIGIT(2), .EARLY_EXIT(1)) u_main (
      .clk(clk), .rst(rst), .start(start_m), .signed_mode(sg), .a(a), .b(b),
      .busy(busy_m), .done(done_m), .gt(gt_m), .eq(eq_m), .lt(lt_m),
      .digits_used(du_m));

   seq_magnitude_compare #(.WIDTH(32), .DIGIT(2), .EARLY_EXIT(0)) u_full (
      .clk(clk), .rst(rst), .start(start_f), .signed_mode(sg), .a(a), .b(b),
      .busy(busy_f), .done(done_f), .gt(gt_f), .eq(eq_f), .lt(lt_f),
      .digits_used(du_f));

   seq_magnitude_compare #(.WIDTH(2), .DIGIT(1), .EARLY_EXIT(1)) u_small (
      .clk(clk), .rst(rst), .start(start_s), .signed_mode(1'b0), .a(a_s), .b(b_s),
      .busy(busy_s), .done(done_s), .gt(gt_s), .eq(eq_s), .lt(lt_s),
      .digits_used(du_s));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Integer-level reference: order from (optionally sign-extended) values,
   // deciding digit from the highest bit where the operands differ.
   function automatic exp_t model(input logic [31:0] va, input logic [31:0] vb, input int w,
                                  input int d, input bit sgn, input bit early);
      exp_t   r;
      longint ia, ib;
      logic [31:0] x;
      int     p;
      int     nd;
      nd = w / d;
      ia = longint'(va);
      ib = longint'(vb);
      if (sgn && va[w-1]) ia = ia - (longint'(1) << w);
      if (sgn && vb[w-1]) ib = ib - (longint'(1) << w);
      r.gt = (ia > ib);
      r.eq = (ia == ib);
      r.lt = (ia < ib);
      r.e0 = 0;
      if (r.eq) begin
         r.du = nd;
      end else begin
         x = va ^ vb;
         p = w - 1;
         while (p > 0 && !x[p]) p--;
         r.du = early ? ((w - 1 - p) / d + 1) : nd;
      end
      r.lat = r.du;
      return r;
   endfunction

   task automatic score(input string tag, input exp_t e, input logic g, input logic q,
                        input logic l, input int du, input int lat);
      check({tag, "_gt"}, 64'(g), 64'(e.gt));
      check({tag, "_eq"}, 64'(q), 64'(e.eq));
      check({tag, "_lt"}, 64'(l), 64'(e.lt));
      check({tag, "_digits_used"}, 64'(du), 64'(e.du));
      check({tag, "_latency"}, 64'(lat), 64'(e.lat));
   endtask

   task automatic spurious(input string tag);
      n_checks++;
      n_fail++;
      $display("FAIL %s_spurious_done: got done=1 expected done=0 (t=%0t)", tag, $time);
   endtask

   // Monitors: a done pulse with nothing outstanding is itself an error.
   always @(negedge clk) begin : mon_main
      exp_t e;
      if (!rst && done_m === 1'b1) begin
         if (q_main.size() == 0) spurious("main");
         else begin
            e = q_main.pop_front();
            score("main", e, gt_m, eq_m, lt_m, int'(du_m), cyc - e.e0);
         end
      end
   end

   always @(negedge clk) begin : mon_full
      exp_t e;
      if (!rst && done_f === 1'b1) begin
         if (q_full.size() == 0) spurious("full");
         else begin
            e = q_full.pop_front();
            score("full", e, gt_f, eq_f, lt_f, int'(du_f), cyc - e.e0);
         end
      end
   end

   always @(negedge clk) begin : mon_small
      exp_t e;
      if (!rst && done_s === 1'b1) begin
         if (q_small.size() == 0) spurious("small");
         else begin
            e = q_small.pop_front();
            score("small", e, gt_s, eq_s, lt_s, int'(du_s), cyc - e.e0);
         end
      end
   end

   // Called just after a falling edge; returns 1 time unit after the
   // accepting edge with the operands scrambled to test the latch.
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input bit isg,
                        input bit to_m, input bit to_f);
      exp_t e;
      a = ia;
      b = ib;
      sg = isg;
      start_m = to_m;
      start_f = to_f;
      if (to_m) begin
         e = model(ia, ib, 32, 2, isg, 1'b1);
         e.e0 = cyc + 1;
         q_main.push_back(e);
      end
      if (to_f) begin
         e = model(ia, ib, 32, 2, isg, 1'b0);
         e.e0 = cyc + 1;
         q_full.push_back(e);
      end
      @(posedge clk);
      #1;
      start_m = 1'b0;
      start_f = 1'b0;
      a = $urandom;
      b = $urandom;
      sg = 1'($urandom);
   endtask

   task automatic issue_small(input logic [1:0] ia, input logic [1:0] ib);
      exp_t e;
      a_s = ia;
      b_s = ib;
      start_s = 1'b1;
      e = model(32'(ia), 32'(ib), 2, 1, 1'b0, 1'b1);
      e.e0 = cyc + 1;
      q_small.push_back(e);
      @(posedge clk);
      #1;
      start_s = 1'b0;
      a_s = 2'($urandom);
      b_s = 2'($urandom);
   endtask

   // Wait for every outstanding result, bounded; returns on a falling edge.
   task automatic drain();
      int n;
      n = 0;
      while ((q_main.size() + q_full.size() + q_small.size()) != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got pending=%0d expected pending=0",
                  q_main.size() + q_full.size() + q_small.size());
         q_main.delete();
         q_full.delete();
         q_small.delete();
      end
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic [31:0] x, y;
      int          n;
      rst = 1'b1;
      start_m = 1'b0;
      start_f = 1'b0;
      start_s = 1'b0;
      sg = 1'b0;
      a = '0;
      b = '0;
      a_s = '0;
      b_s = '0;

      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy_m), 64'd0);
      check("rst_done", 64'(done_m), 64'd0);
      check("rst_flags", 64'({gt_m, eq_m, lt_m}), 64'd0);
      check("rst_digits_used", 64'(du_m), 64'd0);
      check("rst_small_digits_used", 64'(du_s), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Equal operands: full scan on both variants.
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
      check("busy_after_start", 64'(busy_m), 64'd1);
      drain();
      // MSB-only difference: unsigned and signed order disagree.
      issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
      drain();
      issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
      drain();
      // Difference in the last digit, then in the middle.
      issue(32'd3, 32'd2, 1'b0, 1'b1, 1'b1);
      drain();
      issue(32'h0003_0000, 32'h0002_0000, 1'b0, 1'b1, 1'b1);
      drain();

      // A start during RUN is ignored; a start in the done cycle is taken.
      issue(32'd5, 32'd9, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      a = 32'd9;
      b = 32'd5;
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      n = 0;
      while (done_m !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("done_seen_for_back_to_back", 64'(done_m), 64'd1);
      issue(32'hC000_0000, 32'h4000_0000, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("done_not_extended", 64'(done_m), 64'd0);
      check("busy_back_to_back", 64'(busy_m), 64'd1);
      drain();

      // Reset in the middle of a scan aborts it without a done pulse.
      issue(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_busy", 64'({busy_m, busy_f}), 64'd0);
      check("midrst_done", 64'({done_m, done_f}), 64'd0);
      check("midrst_flags", 64'({gt_m, eq_m, lt_m, gt_f, eq_f, lt_f}), 64'd0);
      check("midrst_digits_used", 64'({du_m, du_f}), 64'd0);
      q_main.delete();
      q_full.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle", 64'({busy_m, done_m, du_m}), 64'd0);
      issue(32'd1, 32'd0, 1'b0, 1'b1, 1'b1);
      drain();

      // Exhaustive 2-bit compare, one digit per cycle.
      for (int i = 3; i >= 0; i--) begin
         for (int j = 3; j >= 0; j--) begin
            issue_small(2'(i), 2'(j));
            drain();
         end
      end

      // Randomised operands, biased toward near-equal pairs.
      for (int k = 0; k < 40; k++) begin
         x = $urandom;
         case ($urandom_range(0, 2))
            0: y = $urandom;
            1: y = x ^ (32'd1 << $urandom_range(0, 31));
            default: y = x;
         endcase
         issue(x, y, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
         drain();
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
